// File: rtl/prng_arbiter.sv
// Shared LFSR word server: round-robin grants of one fresh LFSR state per grant,
// with seed sanitising and a WIDTH-cycle warm-up. Optional PRNG_ARB_STATS_EN adds grant_cnt.
module prng_arbiter #(
  parameter int               N_REQ = 4,
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_i,
  output logic [N_REQ-1:0] grant,
  output logic [WIDTH-1:0] rnd_o,
  output logic             rnd_valid,
  output logic             busy,
`ifdef PRNG_ARB_STATS_EN
  output logic [15:0]      grant_cnt,
`endif
  output logic             dbg_state
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {WARMUP = 1'b0, SERVE = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lfsr, lfsr_nxt, lfsr_step;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [WIDTH-1:0] rnd_nxt;
  logic             valid_nxt;
  logic [N_REQ-1:0] pick;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;

  // Right shift, parity of tapped bits enters at the MSB.
  assign lfsr_step = {^(lfsr & TAPS), lfsr[WIDTH-1:1]};
  assign busy      = (state == WARMUP);
  assign dbg_state = state;

  // First set request at or after ptr, searching upward with wrap.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_any && req[idx]) begin
        pick_any = 1'b1;
        pick_idx = PTR_W'(idx);
      end
    end
    if (pick_any) pick[pick_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    grant_nxt = '0;
    rnd_nxt   = '0;
    valid_nxt = 1'b0;
    if (seed_load) begin
      // A zero seed would lock the LFSR, so substitute the default seed.
      lfsr_nxt  = (seed_i == '0) ? SEED : seed_i;
      cnt_nxt   = '0;
      state_nxt = WARMUP;
    end else begin
      case (state)
        WARMUP: begin
          lfsr_nxt = lfsr_step;
          cnt_nxt  = cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt_nxt   = '0;
            state_nxt = SERVE;
          end
        end
        SERVE: begin
          if (pick_any) begin
            grant_nxt = pick;
            rnd_nxt   = lfsr;
            valid_nxt = 1'b1;
            lfsr_nxt  = lfsr_step;
            ptr_nxt   = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
          end
        end
        default: state_nxt = WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WARMUP;
      lfsr      <= SEED;
      ptr       <= '0;
      cnt       <= '0;
      grant     <= '0;
      rnd_o     <= '0;
      rnd_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      grant     <= grant_nxt;
      rnd_o     <= rnd_nxt;
      rnd_valid <= valid_nxt;
    end
  end

`ifdef PRNG_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || seed_load) begin
      grant_cnt <= '0;
    end else if (rnd_valid && grant_cnt != 16'hFFFF) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prng_arbiter.sv
// Self-checking bench for prng_arbiter: behavioural LFSR/arbiter model feeding
// an expected queue, plus fixed-value checks for reset, seeding and period.
module tb_prng_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam logic [W-1:0] TAPS_P = 8'h1D;
  localparam logic [W-1:0] SEED_P = 8'h01;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic         seed_load = 1'b0;
  logic [W-1:0] seed_i = '0;
  logic [N-1:0] grant;
  logic [W-1:0] rnd_o;
  logic         rnd_valid;
  logic         busy;
  logic         dbg_state;
`ifdef PRNG_ARB_STATS_EN
  logic [15:0]  grant_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [N+W:0] exp_q[$];
  logic [W-1:0] m_lfsr;
  int           m_ptr;

  always #5 clk = ~clk;

  prng_arbiter #(.N_REQ(N), .WIDTH(W), .TAPS(TAPS_P), .SEED(SEED_P)) dut (
    .clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed_i(seed_i),
    .grant(grant), .rnd_o(rnd_o), .rnd_valid(rnd_valid), .busy(busy),
`ifdef PRNG_ARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .dbg_state(dbg_state)
  );

  function automatic logic [W-1:0] model_step(input logic [W-1:0] s);
    logic [W-1:0] t;
    logic fb;
    t  = TAPS_P;
    fb = 1'b0;
    for (int i = 0; i < W; i++) if (t[i]) fb = fb ^ s[i];
    return {fb, s[W-1:1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_warmup(input string tag);
    logic exp_b;
    for (int i = 0; i < W; i++) begin
      tick();
      m_lfsr = model_step(m_lfsr);
      exp_b  = (i < W - 1);
      n_tests++;
      if (busy !== exp_b || grant !== '0 || rnd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_warmup[%0d]: busy=%b grant=%b valid=%b, required busy=%b grant=0 valid=0",
                 tag, i, busy, grant, rnd_valid, exp_b);
      end
    end
  endtask

  task automatic serve_cycle(input logic [N-1:0] req_v, output logic [W-1:0] got);
    logic [N+W:0] e;
    logic [N-1:0] g;
    int k;
    req = req_v;
    e   = '0;
    if (req_v != '0) begin
      k = 0;
      while (!req_v[(m_ptr + k) % N]) k++;
      g     = '0;
      g[(m_ptr + k) % N] = 1'b1;
      e     = {g, 1'b1, m_lfsr};
      m_ptr = (m_ptr + k + 1) % N;
      m_lfsr = model_step(m_lfsr);
    end
    exp_q.push_back(e);
    tick();
    e = exp_q.pop_front();
    got = rnd_o;
    n_tests++;
    if ({grant, rnd_valid, rnd_o} !== e || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL serve req=%b: grant=%b valid=%b rnd=%h busy=%b, required grant=%b valid=%b rnd=%h busy=0",
               req_v, grant, rnd_valid, rnd_o, busy, e[N+W:W+1], e[W], e[W-1:0]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    seed_load = 1'b0;
    tick();
    reset = 1'b0;
    m_lfsr = SEED_P;
    m_ptr  = 0;
    exp_q.delete();
    expect_warmup("do_reset");
  endtask

  task automatic test_reset();
    logic [W-1:0] got;
    reset = 1'b1;
    req   = 4'b0001;
    tick();
    tick();
    n_tests++;
    if (grant !== '0 || rnd_o !== '0 || rnd_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b rnd=%h valid=%b busy=%b, required 0/00/0/1",
               grant, rnd_o, rnd_valid, busy);
    end
    reset  = 1'b0;
    m_lfsr = SEED_P;
    m_ptr  = 0;
    expect_warmup("reset");
    serve_cycle(4'b0001, got);
    n_tests++;
    if (got !== 8'h71 || grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_grant: rnd=%h grant=%b, required rnd=71 grant=0001", got, grant);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] vals[8];
    logic dup;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      serve_cycle(4'b1111, vals[i]);
      n_tests++;
      if (grant !== 4'(1 << (i % 4))) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: grant=%b, required %b", i, grant, 4'(1 << (i % 4)));
      end
    end
    dup = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (vals[i] === vals[j]) dup = 1'b1;
    n_tests++;
    if (dup !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_unique: repeat=%b, required 0", dup);
    end
  endtask

  task automatic test_alternate();
    logic [W-1:0] got;
    for (int i = 0; i < 6; i++) begin
      serve_cycle(4'b1010, got);
      n_tests++;
      if (grant !== ((i % 2 == 0) ? 4'b0010 : 4'b1000)) begin
        n_fail++;
        $display("FAIL alt[%0d]: grant=%b, required %b", i, grant,
                 (i % 2 == 0) ? 4'b0010 : 4'b1000);
      end
    end
  endtask

  task automatic test_seed_zero();
    logic [W-1:0] got;
    serve_cycle(4'b0001, got);
    req       = 4'b0001;
    seed_load = 1'b1;
    seed_i    = 8'h00;
    tick();
    seed_load = 1'b0;
    n_tests++;
    if (grant !== '0 || rnd_valid !== 1'b0 || rnd_o !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_zero_cycle: grant=%b valid=%b rnd=%h busy=%b, required 0/0/00/1",
               grant, rnd_valid, rnd_o, busy);
    end
    m_lfsr = SEED_P;
    expect_warmup("seed_zero");
    serve_cycle(4'b0011, got);
    n_tests++;
    if (got !== 8'h71 || grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL seed_zero_first: rnd=%h grant=%b, required rnd=71 grant=0010", got, grant);
    end
  endtask

  task automatic test_seed_restart();
    logic [W-1:0] got;
    seed_load = 1'b1;
    seed_i    = 8'h5A;
    tick();
    seed_load = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_busy: busy=%b, required 1", busy);
    end
    seed_load = 1'b1;
    seed_i    = 8'h3C;
    tick();
    seed_load = 1'b0;
    m_lfsr = 8'h3C;
    expect_warmup("restart");
    for (int i = 0; i < 4; i++) serve_cycle(4'b0100, got);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got;
    for (int i = 0; i < 40; i++) serve_cycle(4'($urandom_range(0, 15)), got);
    serve_cycle(4'b0000, got);
  endtask

  task automatic test_period();
    logic [W-1:0] vals[256];
    logic seen[256];
    int bad;
    do_reset();
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 256; i++) serve_cycle(4'b0001, vals[i]);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      if (vals[i] == '0 || seen[vals[i]]) bad++;
      seen[vals[i]] = 1'b1;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL period_unique: bad_values=%0d, required 0", bad);
    end
    n_tests++;
    if (vals[255] !== vals[0]) begin
      n_fail++;
      $display("FAIL period_wrap: word256=%h, required %h", vals[255], vals[0]);
    end
  endtask

`ifdef PRNG_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    req = 4'b0001;
    repeat (70000) tick();
    req = 4'b0000;
    n_tests++;
    if (grant_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stats_sat: grant_cnt=%h, required FFFF", grant_cnt);
    end
    seed_load = 1'b1;
    seed_i    = 8'h00;
    tick();
    seed_load = 1'b0;
    n_tests++;
    if (grant_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL stats_clear: grant_cnt=%h, required 0000", grant_cnt);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_alternate();
    test_seed_zero();
    test_seed_restart();
    test_back_to_back();
    test_period();
`ifdef PRNG_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
